// File: rtl/msg_sched_if.sv
// msg_sched_if
//   Handshake/data bundle between the message-block source and the
//   SHA-256 message scheduler.
//   start     : request to schedule block_in (source -> scheduler)
//   block_in  : 512-bit padded block, M0 in [511:480] (source -> scheduler)
//   W         : schedule word for the current round (scheduler -> source)
//   w_valid   : W carries a valid word
//   busy      : scheduler is in RUN or DONE
//   done      : one-cycle pulse after the last word
//   round_idx : round counter while w_valid, else 0
//               (present only with MSG_SCHED_ROUND_IDX_EN defined)
interface msg_sched_if;
   logic         start;
   logic [511:0] block_in;
   logic [31:0]  W;
   logic         w_valid;
   logic         busy;
   logic         done;
`ifdef MSG_SCHED_ROUND_IDX_EN
   logic [5:0]   round_idx;
`endif

   modport master (
      output start, block_in,
      input  W, w_valid, busy, done
`ifdef MSG_SCHED_ROUND_IDX_EN
      , input round_idx
`endif
   );

   modport slave (
      input  start, block_in,
      output W, w_valid, busy, done
`ifdef MSG_SCHED_ROUND_IDX_EN
      , output round_idx
`endif
   );
endinterface

// File: rtl/msg_sched.sv
// msg_sched
//   SHA-256 message schedule generator. On start (accepted only in IDLE)
//   the 16 words of block_in are captured into a shift window; the block
//   then emits NUM_ROUNDS schedule words on consecutive cycles, one per
//   clock, followed by a one-cycle done pulse.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : msg_sched_if.slave (start, block_in, W, w_valid, busy, done
//              and optionally round_idx)
//   Build option:
//     MSG_SCHED_ROUND_IDX_EN : adds bus.round_idx for aligning with the
//                              compression stage's K lookup.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; outputs quiet
//   RUN   | emitting window[0] each cycle, window shifts every edge
//   DONE  | one-cycle done pulse, then back to IDLE
module msg_sched #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   msg_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] window_q [16];
   logic [5:0]  round_q;
   logic [31:0] w_new;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // window[0] holds W[t]; the word entering at entry 15 is W[t+16].
   always_comb begin
      w_new = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start) state_d = RUN;
         RUN:  if (round_q == LAST_ROUND) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         round_q <= '0;
         for (int i = 0; i < 16; i++) window_q[i] <= '0;
      end else if (state_q == IDLE && bus.start) begin
         round_q <= '0;
         for (int i = 0; i < 16; i++) window_q[i] <= bus.block_in[511 - 32*i -: 32];
      end else if (state_q == RUN) begin
         round_q <= round_q + 6'd1;
         for (int i = 0; i < 15; i++) window_q[i] <= window_q[i+1];
         window_q[15] <= w_new;
      end
   end

   // Outputs are gated purely by registered state so that reset clears them
   // without waiting for an edge and inputs never reach W combinationally.
   assign bus.W       = (state_q == RUN) ? window_q[0] : 32'd0;
   assign bus.w_valid = (state_q == RUN);
   assign bus.busy    = (state_q == RUN) || (state_q == DONE);
   assign bus.done    = (state_q == DONE);

`ifdef MSG_SCHED_ROUND_IDX_EN
   assign bus.round_idx = (state_q == RUN) ? round_q : 6'd0;
`endif

endmodule

// File: doc/msg_sched.md
MSG_SCHED -- requirements
Module: msg_sched

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 64, the number of schedule words emitted per block.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the request to begin scheduling block_in; sampled on the rising edge of clk.
REQ-005 The block SHALL have port block_in, input, 512, the padded message block; M0 = block_in[511:480], M15 = block_in[31:0].
REQ-006 The block SHALL have port W, output, 32, the schedule word for the current round, feeding the compression pipeline.
REQ-007 The block SHALL have port w_valid, output, 1, high while W carries a valid schedule word.
REQ-008 The block SHALL have port busy, output, 1, high in RUN and DONE.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse after the last word.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE.
REQ-011 IDLE with start=1 at an edge: capture M0..M15 into a 16-entry x 32-bit window (entry 0 = M0), clear the 6-bit round counter, go to RUN.
REQ-012 In RUN: w_valid=1 and W=window[0], driven from registers with no combinational path from inputs.
REQ-013 Each RUN edge: shift the window down one entry, load entry 15 with sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0] mod 2^32, and increment the round counter.
REQ-014 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-015 sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-016 Round t SHALL emit Mt for t<16 and the FIPS 180-4 recurrence value for 16<=t<NUM_ROUNDS.
REQ-017 Latency: the first valid word SHALL appear the cycle after the edge that accepts start; exactly NUM_ROUNDS consecutive valid cycles follow, with no gaps.
REQ-018 The edge at round NUM_ROUNDS-1 SHALL move the state to DONE.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-020 W SHALL be 0 and w_valid 0 in IDLE and DONE.
REQ-021 start in RUN or DONE SHALL be ignored; a new block is accepted only from IDLE, so the earliest restart is the cycle after done.
REQ-022 block_in changes after the accepting edge SHALL NOT affect the block in progress.
REQ-023 Round counter arithmetic SHALL be unsigned; no wrap occurs because RUN exits at NUM_ROUNDS-1.

Reset
REQ-024 Asserting reset at any time, including mid-RUN, SHALL immediately force IDLE, round counter=0, window=0, W=0, w_valid=0, busy=0 and done=0.
REQ-025 The first start accepted after reset deasserts SHALL be processed normally; no partial block is resumed.

Configuration
REQ-026 With macro MSG_SCHED_ROUND_IDX_EN defined, the block SHALL add output round_idx [5:0], equal to the round counter while w_valid=1 and 0 otherwise, for alignment with the compression stage's K lookup.
REQ-027 Without MSG_SCHED_ROUND_IDX_EN, round_idx SHALL be absent and all other behaviour unchanged.

Verification
REQ-028 Scenario: block "abc" (block_in = 0x61626380, fourteen zero words, 0x00000018), start pulse -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; 64 valid cycles; done one cycle later.
REQ-029 Scenario: start held high for 100 cycles -> exactly one block is emitted, done pulses, and a second block begins the cycle after done returns to IDLE.
REQ-030 Scenario: reset asserted at round 30 -> W, w_valid, busy and done are 0 immediately, without waiting for a clock edge; a following start restarts at W0.
REQ-031 Scenario: block_in toggled to all-ones during RUN -> emitted words are identical to the undisturbed "abc" sequence.
REQ-032 Scenario: all-zero block -> all 64 words are 0x00000000 and w_valid stays high for exactly 64 cycles.
REQ-033 Scenario: with MSG_SCHED_ROUND_IDX_EN defined -> round_idx steps 0..63 in lockstep with w_valid and reads 0 in IDLE.
